if_fetch_queue: RTL

//  Fetch stage between the PC register and decode. Issues instruction-memory reads at the current PC.

---
 rtl/if_fetch_queue.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Fetch queue between the PC register and decode. Issues one IMEM read at a
// time at PCF, buffers the returned word with its PC+4 in a small FIFO and
// presents the head entry to ID. PC only advances when memory accepts a read.
//
// Handshakes: a read is accepted in the cycle where imem_req && imem_gnt are
// both high (and no flush is pending). imem_req stays high with a stable
// imem_addr until that happens. The response is a single-cycle imem_rvalid
// pulse, at least one cycle after the grant. On the ID side, an entry is
// consumed in any cycle where ValidD && !StallD && !FlushD.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] PCF,
  input  logic [AW-1:0] PCPlus4F,
  output logic          PCEnF,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  input  logic          StallD,
  input  logic          FlushD,
  output logic          ValidD,
  output logic [DW-1:0] InstrD,
  output logic [AW-1:0] PCPlus4D,
  output logic [1:0]    dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + DW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];

  logic          outstanding;
  logic [CW:0]   occupancy;
  logic          space;
  logic          space_after;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // A read in flight reserves a FIFO slot so its response always fits.
  assign outstanding = (state_q == WAIT);
  assign occupancy   = {1'b0, count_q} + (CW+1)'(outstanding);
  assign space       = occupancy < (CW+1)'(DEPTH);

  assign push   = (state_q == WAIT) && imem_rvalid && !FlushD;
  assign head   = mem_q[rd_ptr_q];
  assign ValidD = (count_q != '0);
  assign pop    = ValidD && !StallD && !FlushD;

  assign InstrD    = ValidD ? head[DW-1:0]  : '0;
  assign PCPlus4D  = ValidD ? head[EW-1:DW] : '0;
  assign dbg_state = state_q;

  // FIFO bookkeeping: flush empties and rewinds, otherwise push/pop update.
  always_comb begin
    count_d  = count_q + CW'(push) - CW'(pop);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    if (FlushD) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
    space_after = count_d < CW'(DEPTH);
  end

  // FIFO storage: the returning word is written together with its PC+4 tag.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {tag_q, imem_rdata};
  end

  // Fetch FSM: request, wait for data, or swallow a response killed by flush.
  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    imem_req  = 1'b0;
    imem_addr = '0;
    PCEnF     = 1'b0;
    case (state_q)
      IDLE: begin
        if (space && !FlushD) state_d = REQ;
      end
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = PCF;
        if (FlushD) begin
          state_d = IDLE;
        end else if (imem_gnt) begin
          PCEnF   = 1'b1;
          tag_d   = PCPlus4F;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (FlushD)           state_d = IDLE;
          else if (space_after) state_d = REQ;
          else                  state_d = IDLE;
        end else if (FlushD) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and FIFO registers; reset wins over every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      tag_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      tag_q    <= tag_d;
      mem_q    <= mem_d;
    end
  end

endmodule
